// File: rtl/dna_read_ctrl.sv
// dna_read_ctrl: reads the device DNA serially and serves 32-bit words to two requesters.
// Ports: clk/rst (async active-high); dna_read/dna_shift/dna_dout drive the DNA primitive;
// start requests a (re)read, busy marks LOAD/SHIFT, valid+dna_o hold the captured DNA;
// req/sel0/sel1 request words, gnt/rdata/rerr return one granted word per cycle.
// Optional macro DNA_AUTO_READ_EN: start a read automatically on the first edge after reset.
module dna_read_ctrl #(
    parameter int DNA_BITS = 96
) (
    input  logic                clk,
    input  logic                rst,
    output logic                dna_read,
    output logic                dna_shift,
    input  logic                dna_dout,
    input  logic                start,
    output logic                busy,
    output logic                valid,
    output logic [DNA_BITS-1:0] dna_o,
    input  logic [1:0]          req,
    input  logic [1:0]          sel0,
    input  logic [1:0]          sel1,
    output logic [1:0]          gnt,
    output logic [31:0]         rdata,
    output logic                rerr
);
    localparam int CW    = $clog2(DNA_BITS);
    localparam int WORDS = DNA_BITS / 32;
`ifdef DNA_AUTO_READ_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t              state, state_n;
    logic [CW-1:0]       cnt;
    logic [DNA_BITS-1:0] sreg;
    logic [127:0]        pad;
    logic [31:0]         word;
    logic [1:0]          w;
    logic                go, fin, pick, grant, oob;
    // set when requester 1 received the most recent grant
    logic                last;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_comb begin
        go        = (state == IDLE && (AUTO || start)) || (state == DONE && start);
        fin       = state == SHIFT && cnt == CW'(DNA_BITS - 1);
        state_n   = go ? LOAD : state == LOAD ? SHIFT : fin ? DONE : state;
        dna_read  = state == LOAD;
        dna_shift = state == SHIFT;
        busy      = dna_read | dna_shift;
    end

    // a grant is suppressed on the edge that starts a re-read, since valid drops there
    always_comb begin
        pick  = req[1] && (!req[0] || !last);
        grant = valid && !go && |req;
        w     = pick ? sel1 : sel0;
        oob   = {1'b0, w} >= 3'(WORDS);
        pad   = {{(128 - DNA_BITS){1'b0}}, dna_o};
        word  = pad[{w, 5'd0} +: 32];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt   <= '0;
            sreg  <= '0;
            dna_o <= '0;
            valid <= 1'b0;
            gnt   <= 2'b00;
            rdata <= '0;
            rerr  <= 1'b0;
            last  <= 1'b1;
        end else begin
            cnt <= state == SHIFT ? cnt + 1'b1 : '0;
            if (state == SHIFT) sreg <= {dna_dout, sreg[DNA_BITS-1:1]};
            // publish the full word on the final shift so dna_o never shows a partial capture
            if (fin) dna_o <= {dna_dout, sreg[DNA_BITS-1:1]};
            valid <= go ? 1'b0 : fin ? 1'b1 : valid;
            gnt   <= grant ? (pick ? 2'b10 : 2'b01) : 2'b00;
            rdata <= grant && !oob ? word : '0;
            rerr  <= grant && oob;
            if (grant) last <= pick;
        end
endmodule
